// File: rtl/mssd_tx_pkg.sv
// Shared definitions for the multi-channel serial frame transmitter.
//   CH_W      channel field width (4 channels)
//   LEN_W     count field width; payload up to DATA_W bits
//   DATA_W    payload register width, 2**LEN_W-1
//   LEN_IW    bits needed to index a bit inside the count field
//   CH_IW     bits needed to index a bit inside the channel field
//   IDLE_LVL  line level while idle, START_LVL level of the start bit
//   tx_state_e  frame field currently driven on the line
package mssd_tx_pkg;

    localparam int unsigned CH_W   = 2;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned DATA_W = (2 ** LEN_W) - 1;
    localparam int unsigned LEN_IW = $clog2(LEN_W);
    localparam int unsigned CH_IW  = $clog2(CH_W);

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_CH,
        ST_CNT,
        ST_DATA,
        ST_PAR
    } tx_state_e;

endpackage

// File: rtl/mssd_bit_cnt.sv
// Loadable down counter used to index the bit being sent within a frame field.
//   clk   clock
//   rst   asynchronous active-high reset, clears the count
//   ld    load val (has priority over en)
//   val   load value
//   en    decrement by one
//   cnt   current count
//   zero  count is zero (last bit of the field)
module mssd_bit_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= val;
        end else if (en) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mssd_frame_tx.sv
// Serial frame transmitter for the multi-channel serial link.
// Frame, one bit per cycle, MSB first per field:
//   start bit (0), channel (CH_W), count (LEN_W), count payload bits [, parity].
// Optional feature: define MSSD_TX_PARITY_EN to append an even-parity bit
// covering channel, count and the payload bits actually sent.
//   clk     clock, rising edge
//   rst     asynchronous active-high reset; aborts any frame at once
//   start   frame request, sampled only while idle
//   ch      destination channel, captured on accept
//   len     payload bit count, captured on accept
//   data    payload, bits [len-1:0] sent
//   serOut  registered serial line, idle high
//   busy    high on every cycle serOut carries a frame bit
//   done    one-cycle pulse on the first idle cycle after a frame
module mssd_frame_tx
    import mssd_tx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CH_W-1:0]   ch,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] data,
    output logic              serOut,
    output logic              busy,
    output logic              done
);

    tx_state_e state_q, state_d, end_state;

    logic [CH_W-1:0]   ch_q;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] data_q;
    logic              capture;

    logic              cnt_ld, cnt_en, cnt_zero;
    logic [LEN_W-1:0]  cnt_val, cnt, idx_d;

    logic              ser_d, ser_q;
    logic              busy_d, busy_q;
    logic              done_d, done_q;

    mssd_bit_cnt #(
        .W (LEN_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .ld   (cnt_ld),
        .val  (cnt_val),
        .en   (cnt_en),
        .cnt  (cnt),
        .zero (cnt_zero)
    );

`ifdef MSSD_TX_PARITY_EN
    logic [DATA_W-1:0] data_mask;
    logic              par_bit;

    assign data_mask = DATA_W'((32'd1 << len_q) - 32'd1);
    assign par_bit   = (^ch_q) ^ (^len_q) ^ (^(data_q & data_mask));
    assign end_state = ST_PAR;
`else
    assign end_state = ST_IDLE;
`endif

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        cnt_ld  = 1'b0;
        cnt_en  = 1'b0;
        cnt_val = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_CH;
                cnt_ld  = 1'b1;
                cnt_val = LEN_W'(CH_W - 1);
            end
            ST_CH: begin
                if (cnt_zero) begin
                    state_d = ST_CNT;
                    cnt_ld  = 1'b1;
                    cnt_val = LEN_W'(LEN_W - 1);
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_CNT: begin
                if (cnt_zero) begin
                    if (len_q != '0) begin
                        state_d = ST_DATA;
                        cnt_ld  = 1'b1;
                        cnt_val = len_q - 1'b1;
                    end else begin
                        state_d = end_state;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_zero) begin
                    state_d = end_state;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_PAR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Index the counter will hold next cycle, so the line bit can be registered
    // together with the state it belongs to.
    always_comb begin
        idx_d = cnt;
        if (cnt_ld) begin
            idx_d = cnt_val;
        end else if (cnt_en) begin
            idx_d = cnt - 1'b1;
        end
    end

    // The start state never reads the capture regs, so using ch_q/len_q/data_q
    // here is safe even on the accept edge where they are still being loaded.
    always_comb begin
        ser_d = IDLE_LVL;
        case (state_d)
            ST_START: ser_d = START_LVL;
            ST_CH:    ser_d = ch_q[idx_d[CH_IW-1:0]];
            ST_CNT:   ser_d = len_q[idx_d[LEN_IW-1:0]];
            ST_DATA:  ser_d = data_q[idx_d];
`ifdef MSSD_TX_PARITY_EN
            ST_PAR:   ser_d = par_bit;
`endif
            default:  ser_d = IDLE_LVL;
        endcase
    end

    assign busy_d = (state_d != ST_IDLE);
    assign done_d = (state_q != ST_IDLE) && (state_d == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ser_q   <= IDLE_LVL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ch_q    <= '0;
            len_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ser_q   <= ser_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (capture) begin
                ch_q   <= ch;
                len_q  <= len;
                data_q <= data;
            end
        end
    end

    assign serOut = ser_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_mssd_frame_tx.sv
// Directed self-checking bench for mssd_frame_tx with hand-computed frame vectors.
// Expected vectors are the default format; with MSSD_TX_PARITY_EN defined the
// hand-computed parity bit given alongside each vector is appended.
module tb_mssd_frame_tx;

`ifdef MSSD_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  ch;
    logic [3:0]  len;
    logic [14:0] data;
    logic        serOut, busy, done;

    int checks = 0;
    int errors = 0;

    mssd_frame_tx dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .ch     (ch),
        .len    (len),
        .data   (data),
        .serOut (serOut),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [1:0] c, input logic [3:0] l, input logic [14:0] d);
        @(negedge clk);
        ch    = c;
        len   = l;
        data  = d;
        start = 1'b1;
    endtask

    // Waits for the accept edge, then checks each frame bit and the done cycle.
    // With hold set, start stays high and inputs switch to nc/nl/nd mid-frame.
    task automatic expect_frame(input string tag, input logic [31:0] bits_in, input int n_in,
                                input logic par, input bit hold, input logic [1:0] nc,
                                input logic [3:0] nl, input logic [14:0] nd);
        logic [31:0] bits;
        int          n;
        bits = PAR_EN ? {bits_in[30:0], par} : bits_in;
        n    = PAR_EN ? n_in + 1 : n_in;
        @(posedge clk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0 && !hold) start = 1'b0;
            if (i == 3 && hold) begin
                ch   = nc;
                len  = nl;
                data = nd;
            end
            check($sformatf("%s bit%0d", tag, i), 32'(serOut), 32'(bits[n-1-i]));
            check($sformatf("%s busy%0d", tag, i), 32'(busy), 32'd1);
            check($sformatf("%s nodone%0d", tag, i), 32'(done), 32'd0);
        end
        @(negedge clk);
        check({tag, " end line"}, 32'(serOut), 32'd1);
        check({tag, " end busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd1);
    endtask

    initial begin
        bit seen_activity;

        rst   = 1'b1;
        start = 1'b0;
        ch    = '0;
        len   = '0;
        data  = '0;
        repeat (2) @(negedge clk);
        check("rst line", 32'(serOut), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        rst = 1'b0;

        // 1: ch=2, len=3, data=101
        launch(2'b10, 4'd3, 15'b101);
        expect_frame("t1", 32'b0_10_0011_101, 10, 1'b1, 1'b0, '0, '0, '0);
        @(negedge clk);
        check("t1 done one cycle", 32'(done), 32'd0);

        // 2: len=0 skips the payload; upper data bits ignored
        launch(2'b11, 4'd0, 15'h7FFF);
        expect_frame("t2", 32'b0_11_0000, 7, 1'b0, 1'b0, '0, '0, '0);

        // 3: maximum payload
        launch(2'b00, 4'd15, 15'h5555);
        expect_frame("t3", 32'b0_00_1111_101010101010101, 22, 1'b0, 1'b0, '0, '0, '0);

        // 4: start held high; inputs change mid-frame; next frame taken on the done cycle
        launch(2'b01, 4'd1, 15'h0001);
        expect_frame("t4a", 32'b0_01_0001_1, 8, 1'b1, 1'b1, 2'b10, 4'd2, 15'b10);
        expect_frame("t4b", 32'b0_10_0010_10, 9, 1'b1, 1'b0, '0, '0, '0);
        @(negedge clk);
        check("t4 idle line", 32'(serOut), 32'd1);
        check("t4 idle busy", 32'(busy), 32'd0);

        // 5: async reset in the middle of the payload of a len=8 frame
        launch(2'b01, 4'd8, 15'h00FF);
        @(posedge clk);
        repeat (9) @(negedge clk);
        start = 1'b0;
        check("t5 busy before rst", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5 async line", 32'(serOut), 32'd1);
        check("t5 async busy", 32'(busy), 32'd0);
        check("t5 async done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_activity = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy || !serOut) seen_activity = 1'b1;
        end
        check("t5 quiet after rst", 32'(seen_activity), 32'd0);

        // 6: ch=1, len=2, data=11 (parity over 4 ones is 0)
        launch(2'b01, 4'd2, 15'b11);
        expect_frame("t6", 32'b0_01_0010_11, 9, 1'b0, 1'b0, '0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
